// File: rtl/ir_calc_core.sv
// ir_calc_core: IR-remote two-operand decimal calculator core.
// Operands A and B are entered digit by digit, signed, and combined by add or
// subtract into a signed result shown on active-low seven-segment digits.
// Every accepted key starts a lockout window of LOCKOUT cycles (busy=1) during
// which further keys are ignored.
// Optional feature macro: IR_CALC_MUL_EN enables the multiply key (0x1B).
module ir_calc_core #(
  parameter int DIGITS  = 2,
  parameter int LOCKOUT = 5000000
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  output logic [7*DIGITS-1:0]     seg_a,
  output logic [7*DIGITS-1:0]     seg_b,
  output logic [14*DIGITS-1:0]    seg_c,
  output logic                    sign_a,
  output logic                    sign_b,
  output logic                    sign_c,
  output logic                    power_on,
  output logic                    busy
);

  localparam int OP_MAX = (10 ** DIGITS) - 1;
  localparam int AW     = $clog2(OP_MAX + 1);
  localparam int RW     = $clog2(OP_MAX * OP_MAX + 1) + 1;
  localparam int CW     = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int DW     = $clog2(DIGITS + 1);

  localparam logic [7:0] K_POWER  = 8'h12;
  localparam logic [7:0] K_EDIT_A = 8'h0F;
  localparam logic [7:0] K_EDIT_B = 8'h13;
  localparam logic [7:0] K_CLEAR  = 8'h10;
  localparam logic [7:0] K_ADD    = 8'h1A;
  localparam logic [7:0] K_SUB    = 8'h1E;
  localparam logic [7:0] K_SIGN   = 8'h0C;
  localparam logic [7:0] K_MUL    = 8'h1B;

  localparam logic [7*DIGITS-1:0]  BLANK_OP  = {DIGITS{7'b1111111}};
  localparam logic [14*DIGITS-1:0] BLANK_RES = {(2*DIGITS){7'b1111111}};

  typedef enum logic [2:0] {ST_OFF, ST_IDLE, ST_EDIT_A, ST_EDIT_B, ST_LOCK} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [1:0] {LAST_NONE, LAST_A, LAST_B} last_t;

  state_t              state_r, ret_r, ret_s;
  op_t                 op_r, op_n_s;
  last_t               last_r, last_n_s;
  logic [CW-1:0]       cnt_r;
  logic [DW-1:0]       dig_r, dig_n_s;
  logic [AW-1:0]       a_r, b_r, a_n_s, b_n_s;
  logic                sa_r, sb_r, sa_n_s, sb_n_s;
  logic                pwr_r, pwr_n_s, busy_r, acc_s;
  logic signed [RW-1:0] opa_s, opb_s, res_s;
  logic [RW-1:0]       mag_s;
  logic [7*DIGITS-1:0] seg_a_r, seg_b_r;
  logic [14*DIGITS-1:0] seg_c_r;
  logic                sign_a_r, sign_b_r, sign_c_r;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Operand magnitude to DIGITS segment codes, leading zeros kept.
  function automatic logic [7*DIGITS-1:0] enc_op(input logic [AW-1:0] v);
    logic [7*DIGITS-1:0] o;
    logic [AW-1:0]       rem;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      o[7*i +: 7] = seg7(4'(rem % AW'(10)));
      rem = rem / AW'(10);
    end
    return o;
  endfunction

  // Result magnitude to 2*DIGITS segment codes, leading zeros kept.
  function automatic logic [14*DIGITS-1:0] enc_res(input logic [RW-1:0] v);
    logic [14*DIGITS-1:0] o;
    logic [RW-1:0]        rem;
    rem = v;
    for (int i = 0; i < 2*DIGITS; i++) begin
      o[7*i +: 7] = seg7(4'(rem % RW'(10)));
      rem = rem / RW'(10);
    end
    return o;
  endfunction

  // Sign-magnitude operand to two's complement at result width.
  function automatic logic [RW-1:0] to_signed(input logic [AW-1:0] mag, input logic neg);
    logic [RW-1:0] ext;
    ext = RW'(mag);
    return neg ? (~ext + RW'(1)) : ext;
  endfunction

  // Signed result of the selected operation and its magnitude.
  always_comb begin
    opa_s = $signed(to_signed(a_r, sa_r));
    opb_s = $signed(to_signed(b_r, sb_r));
    case (op_r)
      OP_ADD:  res_s = opa_s + opb_s;
      OP_SUB:  res_s = opa_s - opb_s;
`ifdef IR_CALC_MUL_EN
      OP_MUL:  res_s = opa_s * opb_s;
`endif
      default: res_s = opa_s + opb_s;
    endcase
    if (res_s[RW-1]) mag_s = $unsigned(-res_s);
    else             mag_s = $unsigned(res_s);
  end

  // Key decode: whether the key is accepted and what it changes.
  always_comb begin
    acc_s    = 1'b0;
    ret_s    = state_r;
    a_n_s    = a_r;
    b_n_s    = b_r;
    sa_n_s   = sa_r;
    sb_n_s   = sb_r;
    op_n_s   = op_r;
    last_n_s = last_r;
    pwr_n_s  = pwr_r;
    dig_n_s  = dig_r;
    if (key_valid) begin
      case (state_r)
        ST_OFF: begin
          if (key_code == K_POWER) begin
            acc_s = 1'b1; pwr_n_s = 1'b1; ret_s = ST_IDLE;
            a_n_s = '0; b_n_s = '0; sa_n_s = 1'b0; sb_n_s = 1'b0;
            op_n_s = OP_ADD; last_n_s = LAST_NONE;
          end else begin
            acc_s = 1'b0;
          end
        end
        ST_IDLE, ST_EDIT_A, ST_EDIT_B: begin
          if (key_code == K_POWER) begin
            acc_s = 1'b1; pwr_n_s = 1'b0; ret_s = ST_OFF;
            a_n_s = '0; b_n_s = '0; sa_n_s = 1'b0; sb_n_s = 1'b0;
          end else if (state_r == ST_IDLE) begin
            case (key_code)
              K_EDIT_A: begin
                acc_s = 1'b1; a_n_s = '0; sa_n_s = 1'b0; dig_n_s = '0;
                last_n_s = LAST_A; ret_s = ST_EDIT_A;
              end
              K_EDIT_B: begin
                acc_s = 1'b1; b_n_s = '0; sb_n_s = 1'b0; dig_n_s = '0;
                last_n_s = LAST_B; ret_s = ST_EDIT_B;
              end
              K_CLEAR: begin
                acc_s = 1'b1; a_n_s = '0; b_n_s = '0;
                sa_n_s = 1'b0; sb_n_s = 1'b0; last_n_s = LAST_NONE;
              end
              K_ADD: begin acc_s = 1'b1; op_n_s = OP_ADD; end
              K_SUB: begin acc_s = 1'b1; op_n_s = OP_SUB; end
`ifdef IR_CALC_MUL_EN
              K_MUL: begin acc_s = 1'b1; op_n_s = OP_MUL; end
`endif
              K_SIGN: begin
                if (last_r == LAST_A) begin
                  acc_s = 1'b1; sa_n_s = ~sa_r;
                end else if (last_r == LAST_B) begin
                  acc_s = 1'b1; sb_n_s = ~sb_r;
                end else begin
                  acc_s = 1'b0;
                end
              end
              default: acc_s = 1'b0;
            endcase
          end else if (key_code < 8'h0A) begin
            acc_s   = 1'b1;
            dig_n_s = dig_r + DW'(1);
            if (state_r == ST_EDIT_B) b_n_s = b_r * AW'(10) + AW'(key_code[3:0]);
            else                      a_n_s = a_r * AW'(10) + AW'(key_code[3:0]);
            if (dig_r == DW'(DIGITS - 1)) ret_s = ST_IDLE;
            else                          ret_s = state_r;
          end else if (key_code == K_SIGN) begin
            acc_s = 1'b1;
            if (state_r == ST_EDIT_B) sb_n_s = ~sb_r;
            else                      sa_n_s = ~sa_r;
          end else begin
            acc_s = 1'b0;
          end
        end
        default: acc_s = 1'b0;
      endcase
    end else begin
      acc_s = 1'b0;
    end
  end

  // Control FSM: apply accepted keys, then hold LOCK for LOCKOUT cycles.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r <= ST_OFF;  ret_r  <= ST_OFF;    cnt_r  <= '0;
      busy_r  <= 1'b0;    pwr_r  <= 1'b0;      dig_r  <= '0;
      a_r     <= '0;      b_r    <= '0;        sa_r   <= 1'b0;  sb_r <= 1'b0;
      op_r    <= OP_ADD;  last_r <= LAST_NONE;
    end else if (state_r == ST_LOCK) begin
      if (cnt_r == CW'(LOCKOUT - 1)) begin
        state_r <= ret_r; busy_r <= 1'b0; cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else if (acc_s) begin
      state_r <= ST_LOCK; ret_r <= ret_s; busy_r <= 1'b1; cnt_r <= '0;
      a_r <= a_n_s; b_r <= b_n_s; sa_r <= sa_n_s; sb_r <= sb_n_s;
      op_r <= op_n_s; last_r <= last_n_s; pwr_r <= pwr_n_s; dig_r <= dig_n_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Display registers: follow operands, signs and result one cycle later.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      seg_a_r <= BLANK_OP; seg_b_r <= BLANK_OP; seg_c_r <= BLANK_RES;
      sign_a_r <= 1'b0; sign_b_r <= 1'b0; sign_c_r <= 1'b0;
    end else begin
      seg_a_r  <= enc_op(a_r);
      seg_b_r  <= enc_op(b_r);
      seg_c_r  <= enc_res(mag_s);
      sign_a_r <= sa_r;
      sign_b_r <= sb_r;
      sign_c_r <= res_s[RW-1];
    end
  end

  assign seg_a    = pwr_r ? seg_a_r : BLANK_OP;
  assign seg_b    = pwr_r ? seg_b_r : BLANK_OP;
  assign seg_c    = pwr_r ? seg_c_r : BLANK_RES;
  assign sign_a   = pwr_r & sign_a_r;
  assign sign_b   = pwr_r & sign_b_r;
  assign sign_c   = pwr_r & sign_c_r;
  assign power_on = pwr_r;
  assign busy     = busy_r;

endmodule
